// File: rtl/ordered_set_tx.sv
// PCIe ordered-set transmitter: expands a one-shot OS request into PIPE beats for
// 8b/10b (gen1/2) symbol mode or 128b/130b (gen3+) block mode.
package ordered_set_tx_pkg;
  typedef enum logic [2:0] {
    RATE_GEN1 = 3'd0,
    RATE_GEN2 = 3'd1,
    RATE_GEN3 = 3'd2,
    RATE_GEN4 = 3'd3,
    RATE_GEN5 = 3'd4
  } rate_speed_e;

  localparam logic [2:0] OS_TS1   = 3'd0;
  localparam logic [2:0] OS_TS2   = 3'd1;
  localparam logic [2:0] OS_EIEOS = 3'd2;
  localparam logic [2:0] OS_SKP   = 3'd3;
  localparam logic [2:0] OS_EIOS  = 3'd4;
  localparam logic [2:0] OS_LIDL  = 3'd5;
endpackage

// state   | meaning
// ST_IDLE | no OS in flight, request accepted immediately
// ST_SEND | presenting beats of the latched OS
module ordered_set_tx
  import ordered_set_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  rate_speed_e             curr_data_rate_i,
  input  logic [5:0]              pipe_width_i,
  input  logic                    os_valid_i,
  input  logic [2:0]              os_type_i,
  output logic                    os_ready_o,
  input  logic [7:0]              link_num_i,
  input  logic [7:0]              lane_num_i,
  input  logic [7:0]              n_fts_i,
  input  logic [7:0]              rate_id_i,
  input  logic [7:0]              train_ctrl_i,
  input  logic [7:0]              symbol6_i,
  input  logic                    link_pad_i,
  input  logic                    lane_pad_i,
  input  logic                    tx_ready_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] data_k_o,
  output logic                    data_valid_o,
  output logic [1:0]              sync_header_o,
  output logic                    start_block_o,
  output logic                    os_done_o
);

  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e            state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic              g3_q, g3_d;
  logic [7:0]        link_q, link_d, lane_q, lane_d, nfts_q, nfts_d;
  logic [7:0]        rid_q, rid_d, ctrl_q, ctrl_d, sym6_q, sym6_d;
  logic              lpad_q, lpad_d, npad_q, npad_d;
  logic [2:0]        bpb_q, bpb_d;
  logic [4:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]  k_q, k_d;
  logic              valid_q, valid_d;
  logic [1:0]        sync_q, sync_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;
  logic              last_q, last_d;

  logic beat_acc, last_acc, accept, load, build;
  logic [7:0] sym_idx;
  logic [8:0] sym;

  function automatic logic [2:0] width_to_bpb(input logic [5:0] w);
    if (w == 6'd32 && LANES >= 4) return 3'd4;
    else if (w == 6'd16 && LANES >= 2) return 3'd2;
    else return 3'd1;
  endfunction

  // Returns {K, byte} for symbol i of the OS.
  function automatic logic [8:0] os_sym(
    input logic [2:0] t,
    input logic       g3,
    input logic [7:0] i,
    input logic [7:0] link,
    input logic [7:0] lane,
    input logic [7:0] nfts,
    input logic [7:0] rid,
    input logic [7:0] ctrl,
    input logic [7:0] s6,
    input logic       lpad,
    input logic       npad
  );
    logic [7:0] b;
    logic       k;
    logic [7:0] fill;
    b    = 8'h00;
    k    = 1'b0;
    fill = (t == OS_TS2) ? 8'h45 : 8'h4A;
    case (t)
      OS_TS1, OS_TS2: begin
        case (i)
          8'd0: begin
            if (g3) b = (t == OS_TS2) ? 8'h2D : 8'h1E;
            else begin b = 8'hBC; k = 1'b1; end
          end
          8'd1: begin
            if (lpad) begin b = 8'hF7; k = !g3; end
            else b = link;
          end
          8'd2: begin
            if (npad) begin b = 8'hF7; k = !g3; end
            else b = lane;
          end
          8'd3: b = nfts;
          8'd4: b = rid;
          8'd5: b = ctrl;
          8'd6: b = s6;
          default: b = fill;
        endcase
      end
      OS_EIEOS: begin
        if (g3) b = i[0] ? 8'hFF : 8'h00;
        else if (i == 8'd0) begin b = 8'hBC; k = 1'b1; end
        else if (i >= 8'd15) b = 8'h4A;
        else begin b = 8'hFC; k = 1'b1; end
      end
      OS_SKP: begin
        if (g3) begin
          if (i < 8'd12) b = 8'hAA;
          else if (i == 8'd12) b = 8'hE1;
          else b = 8'h00;
        end else begin
          b = (i == 8'd0) ? 8'hBC : 8'h1C;
          k = 1'b1;
        end
      end
      OS_EIOS: begin
        if (g3) b = 8'h66;
        else begin
          b = (i == 8'd0) ? 8'hBC : 8'h7C;
          k = 1'b1;
        end
      end
      default: b = 8'h00;
    endcase
    return {k, b};
  endfunction

  assign beat_acc   = valid_q && tx_ready_i;
  assign last_acc   = beat_acc && last_q;
  // Back-to-back acceptance has to see the live tx_ready_i on the final beat.
  assign os_ready_o = rdy_q || last_acc;
  assign accept     = os_valid_i && os_ready_o;
  assign load       = accept && (os_type_i <= OS_LIDL);

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    g3_d    = g3_q;
    link_d  = link_q;
    lane_d  = lane_q;
    nfts_d  = nfts_q;
    rid_d   = rid_q;
    ctrl_d  = ctrl_q;
    sym6_d  = sym6_q;
    lpad_d  = lpad_q;
    npad_d  = npad_q;
    bpb_d   = bpb_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    k_d     = k_q;
    valid_d = valid_q;
    sync_d  = sync_q;
    start_d = start_q;
    build   = 1'b0;
    sym_idx = 8'h00;
    sym     = 9'h000;

    if (load) begin
      type_d  = os_type_i;
      g3_d    = (curr_data_rate_i >= RATE_GEN3);
      link_d  = link_num_i;
      lane_d  = lane_num_i;
      nfts_d  = n_fts_i;
      rid_d   = rate_id_i;
      ctrl_d  = train_ctrl_i;
      sym6_d  = symbol6_i;
      lpad_d  = link_pad_i;
      npad_d  = lane_pad_i;
      bpb_d   = width_to_bpb(pipe_width_i);
      len_d   = (g3_d || os_type_i <= OS_EIEOS) ? 5'd16 : 5'd4;
      idx_d   = 8'h00;
      state_d = ST_SEND;
      valid_d = 1'b1;
      start_d = g3_d;
      sync_d  = g3_d ? ((os_type_i == OS_LIDL) ? 2'b01 : 2'b10) : 2'b00;
      build   = 1'b1;
    end else if (beat_acc) begin
      if (last_q) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        data_d  = '0;
        k_d     = '0;
        start_d = 1'b0;
        sync_d  = 2'b00;
      end else begin
        idx_d   = idx_q + {5'd0, bpb_q};
        start_d = 1'b0;
        build   = 1'b1;
      end
    end

    if (build) begin
      data_d = '0;
      k_d    = '0;
      for (int l = 0; l < LANES; l++) begin
        if (l < int'(bpb_d)) begin
          sym_idx = idx_d + 8'(l);
          sym = os_sym(type_d, g3_d, sym_idx, link_d, lane_d, nfts_d, rid_d,
                       ctrl_d, sym6_d, lpad_d, npad_d);
          data_d[8*l +: 8] = sym[7:0];
          k_d[l]           = sym[8];
        end
      end
    end

    done_d = last_acc;
    rdy_d  = (state_d == ST_IDLE);
    last_d = (state_d == ST_SEND) &&
             (({1'b0, idx_d} + {6'd0, bpb_d}) >= {4'd0, len_d});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      type_q  <= 3'd0;
      g3_q    <= 1'b0;
      link_q  <= 8'h00;
      lane_q  <= 8'h00;
      nfts_q  <= 8'h00;
      rid_q   <= 8'h00;
      ctrl_q  <= 8'h00;
      sym6_q  <= 8'h00;
      lpad_q  <= 1'b0;
      npad_q  <= 1'b0;
      bpb_q   <= 3'd1;
      len_q   <= 5'd0;
      idx_q   <= 8'h00;
      data_q  <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      sync_q  <= 2'b00;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      g3_q    <= g3_d;
      link_q  <= link_d;
      lane_q  <= lane_d;
      nfts_q  <= nfts_d;
      rid_q   <= rid_d;
      ctrl_q  <= ctrl_d;
      sym6_q  <= sym6_d;
      lpad_q  <= lpad_d;
      npad_q  <= npad_d;
      bpb_q   <= bpb_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      start_q <= start_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      last_q  <= last_d;
    end
  end

  assign data_o        = data_q;
  assign data_k_o      = k_q;
  assign data_valid_o  = valid_q;
  assign sync_header_o = sync_q;
  assign start_block_o = start_q;
  assign os_done_o     = done_q;

endmodule

// File: tb/tb_ordered_set_tx.sv
// Directed bench for ordered_set_tx: table of OS requests with hand-written symbol
// streams, plus back-to-back, backpressure, reserved-type and mid-OS reset sequences.
module tb_ordered_set_tx;
  import ordered_set_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  rate_speed_e rate;
  logic [5:0]  width;
  logic        os_valid;
  logic [2:0]  os_type;
  logic        os_ready;
  logic [7:0]  link_num, lane_num, n_fts, rate_id, train_ctrl, symbol6;
  logic        link_pad, lane_pad;
  logic        tx_ready;
  logic [31:0] data;
  logic [3:0]  data_k;
  logic        data_valid;
  logic [1:0]  sync_hdr;
  logic        start_block;
  logic        os_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ordered_set_tx #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .curr_data_rate_i(rate), .pipe_width_i(width),
    .os_valid_i(os_valid), .os_type_i(os_type), .os_ready_o(os_ready),
    .link_num_i(link_num), .lane_num_i(lane_num), .n_fts_i(n_fts),
    .rate_id_i(rate_id), .train_ctrl_i(train_ctrl), .symbol6_i(symbol6),
    .link_pad_i(link_pad), .lane_pad_i(lane_pad), .tx_ready_i(tx_ready),
    .data_o(data), .data_k_o(data_k), .data_valid_o(data_valid),
    .sync_header_o(sync_hdr), .start_block_o(start_block), .os_done_o(os_done)
  );

  typedef struct {
    rate_speed_e  rate;
    logic [5:0]   width;
    logic [2:0]   ostype;
    logic         lpad;
    logic         npad;
    int           bpb;
    int           len;
    logic [1:0]   sync;
    logic         g3;
    logic [127:0] syms;   // symbol n at [8n+:8]
    logic [15:0]  kmask;
    int           stall;  // beat that sees 3 cycles of tx_ready low, -1 for none
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_data(input vec_t v, input int b);
    logic [31:0] d;
    d = '0;
    for (int l = 0; l < v.bpb; l++) d[8*l +: 8] = v.syms[8*(b*v.bpb + l) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] exp_k(input vec_t v, input int b);
    logic [31:0] k;
    k = '0;
    for (int l = 0; l < v.bpb; l++) k[l] = v.kmask[b*v.bpb + l];
    return k;
  endfunction

  task automatic set_fields;
    link_num = 8'h01; lane_num = 8'h02; n_fts = 8'h10;
    rate_id = 8'h02; train_ctrl = 8'h00; symbol6 = 8'h4A;
  endtask

  task automatic scramble(input logic g3);
    os_type = 3'd5; link_num = 8'hEE; lane_num = 8'hEE; n_fts = 8'hEE;
    rate_id = 8'hEE; train_ctrl = 8'hEE; symbol6 = 8'hEE;
    link_pad = ~link_pad; lane_pad = ~lane_pad;
    rate = g3 ? RATE_GEN1 : RATE_GEN3;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int nb;
    string tag;
    tag = $sformatf("v%0d", id);
    nb = v.len / v.bpb;
    set_fields();
    rate = v.rate; width = v.width; os_type = v.ostype;
    link_pad = v.lpad; lane_pad = v.npad; os_valid = 1'b1;
    #1;
    chk({tag, " ready"}, 32'(os_ready), 32'd1);
    tick();
    os_valid = 1'b0;
    scramble(v.g3);
    for (int b = 0; b < nb; b++) begin
      chk($sformatf("%s b%0d valid", tag, b), 32'(data_valid), 32'd1);
      chk($sformatf("%s b%0d data", tag, b), data, exp_data(v, b));
      chk($sformatf("%s b%0d k", tag, b), 32'(data_k), exp_k(v, b));
      chk($sformatf("%s b%0d sync", tag, b), 32'(sync_hdr), 32'(v.sync));
      chk($sformatf("%s b%0d start", tag, b), 32'(start_block), 32'(v.g3 && b == 0));
      if (b == v.stall) begin
        tx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk($sformatf("%s hold%0d data", tag, s), data, exp_data(v, b));
          chk($sformatf("%s hold%0d valid", tag, s), 32'(data_valid), 32'd1);
          chk($sformatf("%s hold%0d done", tag, s), 32'(os_done), 32'd0);
        end
        tx_ready = 1'b1;
      end
      tick();
    end
    chk({tag, " done"}, 32'(os_done), 32'd1);
    chk({tag, " idle valid"}, 32'(data_valid), 32'd0);
    tick();
    chk({tag, " done clear"}, 32'(os_done), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{RATE_GEN1, 6'd32, OS_TS1,   1'b0, 1'b0, 4, 16, 2'b00, 1'b0,
                 128'h4A4A4A4A_4A4A4A4A_4A4A0002_100201BC, 16'h0001, -1};
    vecs[1]  = '{RATE_GEN1, 6'd8,  OS_SKP,   1'b0, 1'b0, 1, 4,  2'b00, 1'b0,
                 128'h1C1C1CBC, 16'h000F, -1};
    vecs[2]  = '{RATE_GEN1, 6'd8,  OS_EIOS,  1'b0, 1'b0, 1, 4,  2'b00, 1'b0,
                 128'h7C7C7CBC, 16'h000F, -1};
    vecs[3]  = '{RATE_GEN3, 6'd32, OS_EIEOS, 1'b0, 1'b0, 4, 16, 2'b10, 1'b1,
                 128'hFF00FF00_FF00FF00_FF00FF00_FF00FF00, 16'h0000, -1};
    vecs[4]  = '{RATE_GEN2, 6'd16, OS_TS2,   1'b1, 1'b0, 2, 16, 2'b00, 1'b0,
                 128'h45454545_45454545_454A0002_1002F7BC, 16'h0003, 2};
    vecs[5]  = '{RATE_GEN1, 6'd16, OS_EIEOS, 1'b0, 1'b0, 2, 16, 2'b00, 1'b0,
                 128'h4AFCFCFC_FCFCFCFC_FCFCFCFC_FCFCFCBC, 16'h7FFF, -1};
    vecs[6]  = '{RATE_GEN3, 6'd32, OS_TS1,   1'b0, 1'b1, 4, 16, 2'b10, 1'b1,
                 128'h4A4A4A4A_4A4A4A4A_4A4A0002_10F7011E, 16'h0000, -1};
    vecs[7]  = '{RATE_GEN3, 6'd16, OS_SKP,   1'b0, 1'b0, 2, 16, 2'b10, 1'b1,
                 128'h000000E1_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, -1};
    vecs[8]  = '{RATE_GEN4, 6'd32, OS_EIOS,  1'b0, 1'b0, 4, 16, 2'b10, 1'b1,
                 128'h66666666_66666666_66666666_66666666, 16'h0000, -1};
    vecs[9]  = '{RATE_GEN3, 6'd8,  OS_LIDL,  1'b0, 1'b0, 1, 16, 2'b01, 1'b1,
                 128'h0, 16'h0000, 5};
    vecs[10] = '{RATE_GEN1, 6'd32, OS_LIDL,  1'b0, 1'b0, 4, 4,  2'b00, 1'b0,
                 128'h0, 16'h0000, -1};
    vecs[11] = '{RATE_GEN1, 6'd24, OS_SKP,   1'b0, 1'b0, 1, 4,  2'b00, 1'b0,
                 128'h1C1C1CBC, 16'h000F, -1};
    vecs[12] = '{RATE_GEN1, 6'd32, OS_TS2,   1'b0, 1'b1, 4, 16, 2'b00, 1'b0,
                 128'h45454545_45454545_454A0002_10F701BC, 16'h0005, -1};

    rst_n = 1'b0; rate = RATE_GEN1; width = 6'd32; os_valid = 1'b0; os_type = 3'd0;
    link_pad = 1'b0; lane_pad = 1'b0; tx_ready = 1'b1;
    set_fields();
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", 32'(data_valid), 32'd0);
    chk("rst data", data, 32'd0);
    chk("rst ready", 32'(os_ready), 32'd0);
    chk("rst done", 32'(os_done), 32'd0);
    chk("rst sync", 32'(sync_hdr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst ready", 32'(os_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reserved type in idle: swallowed without beats or done.
    os_type = 3'd6; os_valid = 1'b1;
    #1;
    chk("rsv ready", 32'(os_ready), 32'd1);
    tick();
    os_valid = 1'b0;
    chk("rsv valid", 32'(data_valid), 32'd0);
    tick();
    chk("rsv done", 32'(os_done), 32'd0);
    chk("rsv ready after", 32'(os_ready), 32'd1);

    // Back-to-back SKP -> EIOS, last SKP beat stalled first, then reserved dropped.
    set_fields();
    rate = RATE_GEN1; width = 6'd8; os_type = OS_SKP; os_valid = 1'b1;
    tick();
    os_valid = 1'b0;
    chk("b2b skp0", data, 32'h000000BC);
    chk("b2b skp0 k", 32'(data_k), 32'h1);
    chk("b2b mid ready", 32'(os_ready), 32'd0);
    tick(); chk("b2b skp1", data, 32'h1C);
    tick(); chk("b2b skp2", data, 32'h1C);
    tick(); chk("b2b skp3", data, 32'h1C);
    tx_ready = 1'b0; os_type = OS_EIOS; os_valid = 1'b1;
    #1;
    chk("b2b stalled ready", 32'(os_ready), 32'd0);
    tick();
    chk("b2b stalled data", data, 32'h1C);
    chk("b2b stalled done", 32'(os_done), 32'd0);
    tx_ready = 1'b1;
    #1;
    chk("b2b last ready", 32'(os_ready), 32'd1);
    tick();
    os_valid = 1'b0;
    chk("b2b eios0", data, 32'hBC);
    chk("b2b eios0 valid", 32'(data_valid), 32'd1);
    chk("b2b skp done", 32'(os_done), 32'd1);
    tick(); chk("b2b eios1", data, 32'h7C); chk("b2b eios1 k", 32'(data_k), 32'h1);
    tick(); chk("b2b eios2", data, 32'h7C);
    tick(); chk("b2b eios3", data, 32'h7C);
    os_type = 3'd7; os_valid = 1'b1;
    #1;
    chk("b2b rsv ready", 32'(os_ready), 32'd1);
    tick();
    os_valid = 1'b0;
    chk("b2b rsv valid", 32'(data_valid), 32'd0);
    chk("b2b eios done", 32'(os_done), 32'd1);
    tick();
    chk("b2b rsv no done", 32'(os_done), 32'd0);

    // Reset in the middle of a gen1 TS1.
    set_fields();
    rate = RATE_GEN1; width = 6'd32; os_type = OS_TS1; os_valid = 1'b1;
    link_pad = 1'b0; lane_pad = 1'b0;
    tick();
    os_valid = 1'b0;
    tick();
    tick();
    chk("mrst beat2", data, 32'h4A4A4A4A);
    rst_n = 1'b0;
    #1;
    chk("mrst valid", 32'(data_valid), 32'd0);
    chk("mrst data", data, 32'd0);
    chk("mrst ready", 32'(os_ready), 32'd0);
    tick();
    chk("mrst done", 32'(os_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst ready after", 32'(os_ready), 32'd1);
    chk("mrst no done", 32'(os_done), 32'd0);
    chk("mrst idle valid", 32'(data_valid), 32'd0);
    run_vec(vecs[1], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ordered_set_tx.md
ORDERED_SET_TX -- requirements
Module: ordered_set_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: maximum PIPE data width in bits (8/16/32 supported).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- curr_data_rate_i  in  rate_speed_e  gen1/gen2 = 8b/10b symbol mode; gen3 and above = 128b/130b block mode.
- pipe_width_i  in  6  active data width in bits (8, 16, 32).
- os_valid_i  in  1  request valid.
- os_type_i  in  3  0 TS1, 1 TS2, 2 EIEOS, 3 SKP, 4 EIOS, 5 LIDL (logical idle), 6-7 reserved.
- os_ready_o  out  1  request accepted when os_valid_i && os_ready_o.
- link_num_i, lane_num_i, n_fts_i, rate_id_i, train_ctrl_i, symbol6_i  in  8 each  TS symbols 1-6.
- link_pad_i, lane_pad_i  in  1 each  send PAD in place of link/lane number.
- tx_ready_i  in  1  downstream PIPE accepts current beat.
- data_o  out  32  symbols, first symbol in data_o[7:0].
- data_k_o  out  4  K flag per byte lane.
- data_valid_o  out  1  beat valid.
- sync_header_o  out  2  gen3 block sync header.
- start_block_o  out  1  first beat of a gen3 block.
- os_done_o  out  1  one-cycle pulse after last beat of an OS is accepted.

Function
REQ-003 SHALL accept a request only in ST_IDLE, or in ST_SEND on the last beat with tx_ready_i=1 (back-to-back, no gap beat).
REQ-004 SHALL latch os_type_i, all TS fields, and curr_data_rate_i at acceptance; later changes SHALL NOT affect the OS in flight.
REQ-005 SHALL drive every output from a register; first beat SHALL appear on data_valid_o the cycle after acceptance.
REQ-006 SHALL use FSM ST_IDLE -> ST_SEND on acceptance; ST_SEND -> ST_IDLE after the last beat is accepted with no new request; ST_SEND -> ST_SEND on a back-to-back accept.
REQ-007 SHALL put bytes_per_beat = pipe_width_i>>3 symbols in each beat; invalid widths SHALL be treated as 8; unused upper lanes SHALL be 0 with K=0.
REQ-008 SHALL advance the 8-bit symbol index by bytes_per_beat only when data_valid_o && tx_ready_i; the beat SHALL hold stable while tx_ready_i=0.
REQ-009 Gen1/2 contents, symbol 0 first:
- TS1/TS2 (16): COM(BC,K); link (F7,K if link_pad_i); lane (F7,K if lane_pad_i); n_fts; rate_id; train_ctrl; symbol6; symbols 7-15 = 4A (TS1) or 45 (TS2), D.
- EIEOS (16): COM, 14x EIE(FC,K), 4A D.
- SKP (4): COM, 3x SKP(1C,K).
- EIOS (4): COM, 3x IDL(7C,K).
- LIDL (4): 00 D.
REQ-010 Gen3 contents, all 16 bytes, sync_header_o=2'b10:
- TS1/TS2: symbol 0 = 1E/2D; symbols 1-6 as REQ-009 with PAD = F7 D; symbols 7-15 = 4A/45.
- EIEOS: 00,FF alternating starting 00.
- SKP: 12x AA, E1, 3x 00.
- EIOS: 16x 66.
- LIDL: sync_header_o=2'b01, 16x 00.
- data_k_o SHALL be 0 in gen3.
REQ-011 start_block_o SHALL be 1 on the first beat of every gen3 OS and 0 otherwise; sync_header_o SHALL be 2'b00 in gen1/2.
REQ-012 Reserved os_type_i SHALL be accepted and dropped: no beats, no os_done_o.
REQ-013 os_done_o SHALL pulse the cycle after the last-beat handshake.

Reset
REQ-014 On rst_ni low, asynchronously: FSM to ST_IDLE, index to 0, data_o=0, data_k_o=0, data_valid_o=0, sync_header_o=0, start_block_o=0, os_done_o=0, os_ready_o=0.
REQ-015 Reset mid-OS SHALL abort the OS with no os_done_o; os_ready_o SHALL be 1 in the first cycle after rst_ni rises.

Verification
REQ-016 Gen1, width 32, TS1, link 01, lane 02, n_fts 10, rate 02, ctrl 00, sym6 4A, tx_ready=1 -> 4 beats: BC/01/02/10 K=0001, then 02/00/4A/4A K=0, 4A x4, 4A x4; os_done next cycle.
REQ-017 Gen1, width 8, SKP -> 4 beats BC,1C,1C,1C all K=1; back-to-back EIOS accepted on last beat -> BC,7C,7C,7C with no gap.
REQ-018 Gen3, width 32, EIEOS -> 4 beats 0xFF00FF00 on data_o, sync 10, start_block on beat 0 only.
REQ-019 Gen2, width 16, TS2, link_pad=1, tx_ready low 3 cycles on beat 2 -> beat 2 held stable, 8 beats total, symbol 1 = F7 K=1.
REQ-020 rst_ni pulsed low at beat 2 of TS1 -> outputs 0 immediately, no os_done; new request then accepted with os_ready_o=1.
